// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer bus: control inputs from the time-compare logic,
// status outputs to the song player and VGA overlay.
interface alarm_sequencer_if;
  logic        sec_tick;
  logic        alarm_on;
  logic        alarm_match;
  logic        snooze_key;
  logic        dismiss_key;
  logic        play_sound;
  logic [1:0]  state;
  logic [3:0]  snooze_count;
  logic [15:0] sec_count;
  logic        timeout;

  modport master (
    output sec_tick,
    output alarm_on,
    output alarm_match,
    output snooze_key,
    output dismiss_key,
    input  play_sound,
    input  state,
    input  snooze_count,
    input  sec_count,
    input  timeout
  );

  modport slave (
    input  sec_tick,
    input  alarm_on,
    input  alarm_match,
    input  snooze_key,
    input  dismiss_key,
    output play_sound,
    output state,
    output snooze_count,
    output sec_count,
    output timeout
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on enable, rings on a match edge, handles
// snooze/dismiss keys, ring timeout and snooze limit.
module alarm_sequencer #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input logic               clk,
  input logic               reset,
  alarm_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

  localparam logic [15:0] RING_LAST = 16'(RING_SECS - 1);
  localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_SECS - 1);
  localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZE);

  state_e      state_q;
  logic        match_q;
  logic [3:0]  snz_q;
  logic [15:0] sec_q;
  logic        timeout_q;
  logic        match_rise;

  assign match_rise = bus.alarm_match & ~match_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      match_q   <= 1'b0;
      snz_q     <= 4'd0;
      sec_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      match_q   <= bus.alarm_match;
      timeout_q <= 1'b0;
      if (!bus.alarm_on) begin
        state_q <= IDLE;
        snz_q   <= 4'd0;
        sec_q   <= 16'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (match_rise) begin
              state_q <= RINGING;
              snz_q   <= 4'd0;
              sec_q   <= 16'd0;
            end
          end
          RINGING: begin
            // a snooze key at the limit is dropped, so a tick still counts
            if (bus.dismiss_key) begin
              state_q <= ARMED;
            end else if (bus.snooze_key && snz_q < SNZ_MAX) begin
              state_q <= SNOOZE;
              snz_q   <= snz_q + 4'd1;
              sec_q   <= 16'd0;
            end else if (bus.sec_tick) begin
              if (sec_q == RING_LAST) begin
                state_q   <= ARMED;
                timeout_q <= 1'b1;
              end else begin
                sec_q <= sec_q + 16'd1;
              end
            end
          end
          SNOOZE: begin
            if (bus.dismiss_key) begin
              state_q <= ARMED;
            end else if (bus.sec_tick) begin
              if (sec_q == SNZ_LAST) begin
                state_q <= RINGING;
                sec_q   <= 16'd0;
              end else begin
                sec_q <= sec_q + 16'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.play_sound   = (state_q == RINGING);
  assign bus.state        = state_q;
  assign bus.snooze_count = snz_q;
  assign bus.sec_count    = sec_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: driver queues hand-computed
// expectations, monitor pops and checks after each edge.
module tb_alarm_sequencer;

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  snz;
    logic [15:0] sec;
    logic        to;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   id = 0;
  exp_t q[$];

  alarm_sequencer_if bus();

  alarm_sequencer #(
    .RING_SECS(4),
    .SNOOZE_SECS(3),
    .MAX_SNOOZE(2)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int sid,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL step%0d %s got=%0d exp=%0d",
               sid, nm, got, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk or negedge rst_n);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", e.id, 16'(bus.state), 16'(e.st));
      chk("play", e.id, 16'(bus.play_sound),
          16'(e.st == 2'd2));
      chk("snooze_count", e.id, 16'(bus.snooze_count),
          16'(e.snz));
      chk("sec_count", e.id, bus.sec_count, e.sec);
      chk("timeout", e.id, 16'(bus.timeout), 16'(e.to));
    end
  end

  task automatic expect_push(input logic [1:0] es,
                             input logic [3:0] ec,
                             input logic [15:0] esec,
                             input logic eto);
    exp_t e;
    e.st = es;
    e.snz = ec;
    e.sec = esec;
    e.to = eto;
    e.id = id;
    id++;
    q.push_back(e);
  endtask

  // on, match, tick, snooze, dismiss | state, snz, sec, timeout
  task automatic step(input logic on, input logic m,
                      input logic t, input logic s,
                      input logic d,
                      input logic [1:0] es,
                      input logic [3:0] ec,
                      input logic [15:0] esec,
                      input logic eto);
    @(negedge clk);
    bus.alarm_on = on;
    bus.alarm_match = m;
    bus.sec_tick = t;
    bus.snooze_key = s;
    bus.dismiss_key = d;
    expect_push(es, ec, esec, eto);
  endtask

  initial begin
    bus.alarm_on = 1'b0;
    bus.alarm_match = 1'b0;
    bus.sec_tick = 1'b0;
    bus.snooze_key = 1'b0;
    bus.dismiss_key = 1'b0;
    // reset held: outputs at reset values
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // 1: arm, then ring on match edge
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 2, 0, 0, 0);
    // 2: ring timeout, match still high
    step(1, 1, 1, 0, 0, 2, 0, 1, 0);
    step(1, 1, 1, 0, 0, 2, 0, 2, 0);
    step(1, 1, 1, 0, 0, 2, 0, 3, 0);
    step(1, 1, 1, 0, 0, 1, 0, 3, 1);
    step(1, 1, 0, 0, 0, 1, 0, 3, 0);
    step(1, 1, 0, 0, 0, 1, 0, 3, 0);
    // 3: snooze cycles up to the limit
    step(1, 0, 0, 0, 0, 1, 0, 3, 0);
    step(1, 1, 0, 0, 0, 2, 0, 0, 0);
    step(1, 1, 0, 1, 0, 3, 1, 0, 0);
    step(1, 1, 1, 0, 0, 3, 1, 1, 0);
    step(1, 1, 1, 0, 0, 3, 1, 2, 0);
    step(1, 1, 1, 0, 0, 2, 1, 0, 0);
    step(1, 1, 0, 1, 0, 3, 2, 0, 0);
    step(1, 1, 1, 0, 0, 3, 2, 1, 0);
    step(1, 1, 1, 0, 0, 3, 2, 2, 0);
    step(1, 1, 1, 0, 0, 2, 2, 0, 0);
    step(1, 1, 0, 1, 0, 2, 2, 0, 0);
    step(1, 1, 1, 0, 0, 2, 2, 1, 0);
    // 4: dismiss beats snooze; counters held
    step(1, 1, 0, 1, 1, 1, 2, 1, 0);
    step(1, 0, 0, 0, 0, 1, 2, 1, 0);
    step(1, 1, 0, 0, 0, 2, 0, 0, 0);
    // key with tick: only the key acts
    step(1, 1, 1, 1, 0, 3, 1, 0, 0);
    step(1, 1, 1, 0, 1, 1, 1, 0, 0);
    // 5: enable while match already high
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 2, 0, 0, 0);
    // 6: drop enable mid-snooze
    step(1, 1, 0, 1, 0, 3, 1, 0, 0);
    step(1, 1, 1, 0, 0, 3, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 2, 0, 0, 0);
    step(1, 1, 1, 0, 0, 2, 0, 1, 0);
    // async reset mid-ring, checked between edges
    @(negedge clk);
    #2;
    expect_push(0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequences the alarm once the current time matches the programmed alarm time. The block sits between the time-compare logic and the song player. It arms on the alarm-enable switch and starts ringing on a match edge. It handles snooze and dismiss key pulses, limits ring duration and snooze count, and drives the player's `playSound` input plus status for the VGA overlay.

## Interface
- `RING_SECS`, 60, seconds of ringing before an automatic stop (1..65535)
- `SNOOZE_SECS`, 300, seconds spent in snooze before ringing resumes (1..65535)
- `MAX_SNOOZE`, 3, maximum snoozes per alarm event (0..15)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `sec_tick`  in  1  one-`clk`-wide pulse once per second, synchronous to `clk`
- `alarm_on`  in  1  alarm enable level (switch, pre-synchronised)
- `alarm_match`  in  1  level; high while current time equals alarm time
- `snooze_key`  in  1  one-cycle key pulse
- `dismiss_key`  in  1  one-cycle key pulse
- `play_sound`  out  1  high while in RINGING
- `state`  out  2  0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE
- `snooze_count`  out  4  snoozes used in the current alarm event
- `sec_count`  out  16  seconds elapsed in the current RINGING or SNOOZE interval
- `timeout`  out  1  one-cycle pulse when ringing ends by `RING_SECS` expiry

## Operation
- `match_d` register samples `alarm_match` every cycle, in all states. `match_rise = alarm_match & ~match_d`.
- State transitions:
  - IDLE: go to ARMED when `alarm_on` = 1.
  - ARMED: go to RINGING on `match_rise`. Clear `sec_count` and `snooze_count`.
  - RINGING, in priority order:
    - `dismiss_key` → ARMED.
    - `snooze_key` with `snooze_count` < `MAX_SNOOZE` → SNOOZE. Increment `snooze_count` and clear `sec_count`.
    - `snooze_key` at the limit is ignored.
    - `sec_tick` with `sec_count` == `RING_SECS`-1 → ARMED and pulse `timeout`.
    - Any other `sec_tick` increments `sec_count`.
  - SNOOZE, in priority order:
    - `dismiss_key` → ARMED.
    - `sec_tick` with `sec_count` == `SNOOZE_SECS`-1 → RINGING. Clear `sec_count`; `snooze_count` is held.
    - Any other `sec_tick` increments `sec_count`.
    - `snooze_key` is ignored.
- `alarm_on` = 0 in any state forces IDLE. This has the highest priority and clears `sec_count` and `snooze_count`.
- Ringing is edge-triggered only:
  - Enabling the alarm while `alarm_match` is already high does not ring.
  - Dismiss or timeout during the matching second does not re-trigger.
- On the transition to ARMED, `snooze_count` and `sec_count` hold their values; they are cleared on the next ARMED → RINGING.
- Arithmetic:
  - `sec_count` is unsigned 16-bit and never exceeds max(`RING_SECS`, `SNOOZE_SECS`)-1, so it never wraps.
  - `snooze_count` saturates at `MAX_SNOOZE`.
  - `MAX_SNOOZE` = 0 disables snooze.

## Timing
- Reset values: state IDLE, `play_sound` 0, `snooze_count` 0, `sec_count` 0, `timeout` 0, `match_d` 0.
- Reset is asynchronous, effective mid-ring, and silences sound immediately.
- All outputs are registered. `play_sound` is decoded from the state register, so it goes high on the same edge that enters RINGING.
- Latency:
  - `alarm_match` rising at cycle N (sampled edge N) → `state` = 2 and `play_sound` = 1 after edge N.
  - Key pulse sampled at edge N → new state after edge N.
- `timeout` is high for exactly the cycle following the expiring edge.
- Simultaneous events in RINGING or SNOOZE resolve as: `alarm_on` low > dismiss > snooze > `sec_tick`.
- A key pulse coincident with `sec_tick` applies only the key action; the tick is not counted.

## Test plan
Parameters for all scenarios: `RING_SECS` = 4, `SNOOZE_SECS` = 3, `MAX_SNOOZE` = 2.

1. Reset low → all outputs 0 and state 0. Raise `alarm_on` → state 1 on the next edge. Pulse `alarm_match` high → state 2 and `play_sound` 1 one edge later.
2. Ringing with no keys, 4 `sec_tick`s → state 1, `timeout` pulses once, `play_sound` 0. `alarm_match` still high → no re-ring.
3. Ringing, `snooze_key` → state 3 and `snooze_count` 1. 3 ticks → state 2 and `sec_count` 0. Snooze again → `snooze_count` 2. After 3 ticks, a third snooze → remains in state 2 with `snooze_count` 2.
4. Ringing, `dismiss_key` and `snooze_key` in the same cycle → state 1, `snooze_count` unchanged. Next match edge → state 2 with `snooze_count` 0.
5. `alarm_match` high before `alarm_on` rises → state 1, never 2, until match falls and rises again.
6. In SNOOZE at `sec_count` 1, drop `alarm_on` → state 0 and counters 0. Assert `reset` low mid-RINGING → `play_sound` 0 with no clock edge.
